// File: rtl/rl_lj_pair_dispatcher.sv
// ============================================================================
// rl_lj_pair_dispatcher : (ref, neighbour) pair feeder for the LJ force tile.
// Optional self-pair skipping: define PAIR_SKIP_SELF_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module rl_lj_pair_dispatcher #(
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 16,
  parameter int COUNT_WIDTH     = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ref_valid_i,
  output logic                   ref_ready_o,
  input  logic [DATA_WIDTH-1:0]  ref_x_i,
  input  logic [DATA_WIDTH-1:0]  ref_y_i,
  input  logic [DATA_WIDTH-1:0]  ref_z_i,
  input  logic [ID_WIDTH-1:0]    ref_id_i,
  input  logic [COUNT_WIDTH-1:0] ref_nbr_count_i,
  input  logic                   nbr_valid_i,
  output logic                   nbr_ready_o,
  input  logic [DATA_WIDTH-1:0]  nbr_x_i,
  input  logic [DATA_WIDTH-1:0]  nbr_y_i,
  input  logic [DATA_WIDTH-1:0]  nbr_z_i,
  input  logic [ID_WIDTH-1:0]    nbr_id_i,
  output logic                   pair_valid_o,
  input  logic                   pair_ready_i,
  output logic [DATA_WIDTH-1:0]  pair_ref_x_o,
  output logic [DATA_WIDTH-1:0]  pair_ref_y_o,
  output logic [DATA_WIDTH-1:0]  pair_ref_z_o,
  output logic [DATA_WIDTH-1:0]  pair_nbr_x_o,
  output logic [DATA_WIDTH-1:0]  pair_nbr_y_o,
  output logic [DATA_WIDTH-1:0]  pair_nbr_z_o,
  output logic [ID_WIDTH-1:0]    pair_ref_id_o,
  output logic                   pair_last_o,
  output logic                   ref_done_o,
`ifdef PAIR_SKIP_SELF_EN
  output logic [COUNT_WIDTH-1:0] skip_count_o,
`endif
  output logic                   busy_o
);

  localparam int ENTRY_W = 3*DATA_WIDTH + ID_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [ENTRY_W-1:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   occ_q, occ_d;
  logic [COUNT_WIDTH-1:0]     remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]      ref_x_q, ref_y_q, ref_z_q, ref_x_d, ref_y_d, ref_z_d;
  logic [ID_WIDTH-1:0]        ref_id_q, ref_id_d;
  logic [DATA_WIDTH-1:0]      nbr_x_q, nbr_y_q, nbr_z_q, nbr_x_d, nbr_y_d, nbr_z_d;
  logic [DATA_WIDTH-1:0]      pref_x_q, pref_y_q, pref_z_q, pref_x_d, pref_y_d, pref_z_d;
  logic [ID_WIDTH-1:0]        pref_id_q, pref_id_d;
  logic                       pair_valid_q, pair_valid_d;
  logic                       pair_last_q, pair_last_d;
  logic                       ref_done_q, ref_done_d;
  logic [COUNT_WIDTH-1:0]     skip_count_q, skip_count_d;

  logic [ENTRY_W-1:0] head;
  logic               fifo_empty, push, pop, load, skip;
  logic               ref_accept, pair_accept, rem_is_one;

  assign head        = mem_q[rd_ptr_q];
  assign fifo_empty  = (occ_q == '0);
  assign nbr_ready_o = (occ_q != (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign push        = nbr_valid_i && nbr_ready_o;
  assign ref_accept  = ref_valid_i && ref_ready_o;
  assign pair_accept = pair_valid_q && pair_ready_i;
  assign rem_is_one  = (remaining_q == COUNT_WIDTH'(1));

`ifdef PAIR_SKIP_SELF_EN
  assign skip = (state_q == S_STREAM) && !fifo_empty && (head[ID_WIDTH-1:0] == ref_id_q);
`else
  assign skip = 1'b0;
`endif
  assign load = (state_q == S_STREAM) && !fifo_empty && !skip && (!pair_valid_q || pair_ready_i);
  assign pop  = load || skip;
  assign occ_d = occ_q + (FIFO_ADDR_WIDTH+1)'(push) - (FIFO_ADDR_WIDTH+1)'(pop);

  // Storage has no reset: pointers and occupancy alone define the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {nbr_x_i, nbr_y_i, nbr_z_i, nbr_id_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ref_accept) state_d = (ref_nbr_count_i == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (pop && rem_is_one) begin
                  // A skipped final entry only needs DRAIN if a pair is still held.
                  if (load || (pair_valid_q && !pair_ready_i)) state_d = S_DRAIN;
                  else                                         state_d = S_DONE;
                end
      S_DRAIN:  if (pair_accept) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
  end

  always_comb begin
    ref_x_d = ref_x_q;  ref_y_d = ref_y_q;  ref_z_d = ref_z_q;  ref_id_d = ref_id_q;
    remaining_d  = remaining_q;
    skip_count_d = skip_count_q;
    pref_x_d = pref_x_q;  pref_y_d = pref_y_q;  pref_z_d = pref_z_q;  pref_id_d = pref_id_q;
    nbr_x_d  = nbr_x_q;   nbr_y_d  = nbr_y_q;   nbr_z_d  = nbr_z_q;
    pair_valid_d = pair_valid_q;
    pair_last_d  = pair_last_q;
    ref_done_d   = (state_q == S_DONE);
    if (ref_accept) begin
      ref_x_d = ref_x_i;  ref_y_d = ref_y_i;  ref_z_d = ref_z_i;  ref_id_d = ref_id_i;
      remaining_d  = ref_nbr_count_i;
      skip_count_d = '0;
    end
    if (pop) remaining_d = remaining_q - COUNT_WIDTH'(1);
    if (skip) skip_count_d = skip_count_q + COUNT_WIDTH'(1);
    if (load) begin
      pref_x_d = ref_x_q;  pref_y_d = ref_y_q;  pref_z_d = ref_z_q;  pref_id_d = ref_id_q;
      {nbr_x_d, nbr_y_d, nbr_z_d} = head[ENTRY_W-1:ID_WIDTH];
      pair_valid_d = 1'b1;
      pair_last_d  = rem_is_one;
    end else if (pair_accept) begin
      pair_valid_d = 1'b0;
      pair_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  occ_q <= '0;
      ref_x_q <= '0;  ref_y_q <= '0;  ref_z_q <= '0;  ref_id_q <= '0;
      remaining_q <= '0;  skip_count_q <= '0;
      pref_x_q <= '0;  pref_y_q <= '0;  pref_z_q <= '0;  pref_id_q <= '0;
      nbr_x_q <= '0;  nbr_y_q <= '0;  nbr_z_q <= '0;
      pair_valid_q <= 1'b0;  pair_last_q <= 1'b0;  ref_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      occ_q <= occ_d;
      ref_x_q <= ref_x_d;  ref_y_q <= ref_y_d;  ref_z_q <= ref_z_d;  ref_id_q <= ref_id_d;
      remaining_q <= remaining_d;  skip_count_q <= skip_count_d;
      pref_x_q <= pref_x_d;  pref_y_q <= pref_y_d;  pref_z_q <= pref_z_d;  pref_id_q <= pref_id_d;
      nbr_x_q <= nbr_x_d;  nbr_y_q <= nbr_y_d;  nbr_z_q <= nbr_z_d;
      pair_valid_q <= pair_valid_d;  pair_last_q <= pair_last_d;  ref_done_q <= ref_done_d;
    end
  end

  assign pair_valid_o  = pair_valid_q;
  assign pair_ref_x_o  = pref_x_q;
  assign pair_ref_y_o  = pref_y_q;
  assign pair_ref_z_o  = pref_z_q;
  assign pair_ref_id_o = pref_id_q;
  assign pair_nbr_x_o  = nbr_x_q;
  assign pair_nbr_y_o  = nbr_y_q;
  assign pair_nbr_z_o  = nbr_z_q;
  assign pair_last_o   = pair_last_q;
  assign ref_done_o    = ref_done_q;
`ifdef PAIR_SKIP_SELF_EN
  assign skip_count_o  = skip_count_q;
`else
  logic unused_skip;
  assign unused_skip = ^skip_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rl_lj_pair_dispatcher.sv
// ============================================================================
// tb_rl_lj_pair_dispatcher : directed self-checking bench for the dispatcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rl_lj_pair_dispatcher;

  logic        clk, rst;
  logic        ref_valid, ref_ready;
  logic [31:0] ref_x, ref_y, ref_z;
  logic [15:0] ref_id, ref_nbr_count;
  logic        nbr_valid, nbr_ready;
  logic [31:0] nbr_x, nbr_y, nbr_z;
  logic [15:0] nbr_id;
  logic        pair_valid, pair_ready;
  logic [31:0] pair_ref_x, pair_ref_y, pair_ref_z, pair_nbr_x, pair_nbr_y, pair_nbr_z;
  logic [15:0] pair_ref_id;
  logic        pair_last, ref_done, busy;
`ifdef PAIR_SKIP_SELF_EN
  logic [15:0] skip_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rl_lj_pair_dispatcher dut (
    .clk(clk), .rst(rst),
    .ref_valid_i(ref_valid), .ref_ready_o(ref_ready),
    .ref_x_i(ref_x), .ref_y_i(ref_y), .ref_z_i(ref_z),
    .ref_id_i(ref_id), .ref_nbr_count_i(ref_nbr_count),
    .nbr_valid_i(nbr_valid), .nbr_ready_o(nbr_ready),
    .nbr_x_i(nbr_x), .nbr_y_i(nbr_y), .nbr_z_i(nbr_z), .nbr_id_i(nbr_id),
    .pair_valid_o(pair_valid), .pair_ready_i(pair_ready),
    .pair_ref_x_o(pair_ref_x), .pair_ref_y_o(pair_ref_y), .pair_ref_z_o(pair_ref_z),
    .pair_nbr_x_o(pair_nbr_x), .pair_nbr_y_o(pair_nbr_y), .pair_nbr_z_o(pair_nbr_z),
    .pair_ref_id_o(pair_ref_id), .pair_last_o(pair_last), .ref_done_o(ref_done),
`ifdef PAIR_SKIP_SELF_EN
    .skip_count_o(skip_count),
`endif
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] x, input logic [15:0] id);
    nbr_valid = 1'b1; nbr_x = x; nbr_y = x + 32'd1; nbr_z = x + 32'd2; nbr_id = id;
    tick();
    nbr_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [31:0] x, input logic [15:0] id, input logic [15:0] cnt);
    ref_valid = 1'b1; ref_x = x; ref_y = x + 32'd1; ref_z = x + 32'd2;
    ref_id = id; ref_nbr_count = cnt;
    tick();
    ref_valid = 1'b0;
  endtask

  initial begin
    int got;
    logic [15:0] ids4 [5];
    rst = 1'b1; ref_valid = 0; nbr_valid = 0; pair_ready = 0;
    ref_x = 0; ref_y = 0; ref_z = 0; ref_id = 0; ref_nbr_count = 0;
    nbr_x = 0; nbr_y = 0; nbr_z = 0; nbr_id = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_pair_valid", pair_valid, 1'b0);
    check("rst_ref_ready",  ref_ready,  1'b1);
    check("rst_nbr_ready",  nbr_ready,  1'b1);
    check("rst_busy",       busy,       1'b0);
    check("rst_ref_done",   ref_done,   1'b0);
    check("rst_pair_nbr_x", pair_nbr_x, 32'h0);

    // Three neighbours, pair_ready held high
    pair_ready = 1'b1;
    push(32'h4000_0000, 16'h0001);
    push(32'h4000_0010, 16'h0002);
    push(32'h4000_0020, 16'h0003);
    send_ref(32'h3F80_0000, 16'h0055, 16'd3);
    check("t1_busy", busy, 1'b1);
    check("t1_ref_ready", ref_ready, 1'b0);
    check("t1_no_pair_yet", pair_valid, 1'b0);
    tick();
    check("t1_p0_valid", pair_valid, 1'b1);
    check("t1_p0_nbr_x", pair_nbr_x, 32'h4000_0000);
    check("t1_p0_nbr_z", pair_nbr_z, 32'h4000_0002);
    check("t1_p0_ref_x", pair_ref_x, 32'h3F80_0000);
    check("t1_p0_ref_y", pair_ref_y, 32'h3F80_0001);
    check("t1_p0_ref_id", pair_ref_id, 16'h0055);
    check("t1_p0_last", pair_last, 1'b0);
    tick();
    check("t1_p1_valid", pair_valid, 1'b1);
    check("t1_p1_nbr_x", pair_nbr_x, 32'h4000_0010);
    check("t1_p1_last", pair_last, 1'b0);
    tick();
    check("t1_p2_valid", pair_valid, 1'b1);
    check("t1_p2_nbr_y", pair_nbr_y, 32'h4000_0021);
    check("t1_p2_last", pair_last, 1'b1);
    tick();
    check("t1_drain_valid", pair_valid, 1'b0);
    check("t1_drain_last", pair_last, 1'b0);
    check("t1_drain_done", ref_done, 1'b0);
    check("t1_drain_busy", busy, 1'b1);
    tick();
    check("t1_done_pulse", ref_done, 1'b1);
    check("t1_done_busy", busy, 1'b0);
    check("t1_done_ref_ready", ref_ready, 1'b1);
    tick();
    check("t1_done_low", ref_done, 1'b0);

    // Zero-count reference leaves buffered neighbours for the next one
    push(32'h4200_0000, 16'h00A0);
    push(32'h4200_0010, 16'h00A1);
    send_ref(32'h3F00_0000, 16'h0066, 16'd0);
    check("t2_busy", busy, 1'b1);
    check("t2_no_pair", pair_valid, 1'b0);
    check("t2_done_early", ref_done, 1'b0);
    tick();
    check("t2_done_pulse", ref_done, 1'b1);
    check("t2_no_pair2", pair_valid, 1'b0);
    tick();
    check("t2_done_low", ref_done, 1'b0);
    send_ref(32'h3E00_0000, 16'h0067, 16'd2);
    tick();
    check("t2_p0_id", pair_nbr_x, 32'h4200_0000);
    check("t2_p0_ref", pair_ref_id, 16'h0067);
    tick();
    check("t2_p1_id", pair_nbr_x, 32'h4200_0010);
    check("t2_p1_last", pair_last, 1'b1);
    tick();
    tick();
    check("t2_b_done", ref_done, 1'b1);

    // Fill the FIFO with no reference loaded
    pair_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h4100_0000 + i, 16'h0010 + 16'(i));
    check("t3_full_nbr_ready", nbr_ready, 1'b0);
    nbr_valid = 1'b1; nbr_x = 32'h4100_0010; nbr_y = 32'h4100_0011;
    nbr_z = 32'h4100_0012; nbr_id = 16'h0020;
    tick(); tick();
    check("t3_held_nbr_ready", nbr_ready, 1'b0);
    pair_ready = 1'b1;
    send_ref(32'h3C00_0000, 16'h0077, 16'd17);
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 0) check("t3_ready_after_pop", nbr_ready, 1'b1);
      if (i == 1) nbr_valid = 1'b0;
      check("t3_valid", pair_valid, 1'b1);
      check("t3_order_id", pair_nbr_x, 32'h4100_0000 + i);
      check("t3_last", pair_last, (i == 16) ? 1'b1 : 1'b0);
    end
    tick();
    check("t3_drained", pair_valid, 1'b0);
    tick();
    check("t3_done", ref_done, 1'b1);

    // Stalled output: pair_ready high one cycle in three
    pair_ready = 1'b0;
    ids4 = '{16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0035};
    for (int i = 0; i < 5; i++) push(32'h4300_0000 + 32'(ids4[i]), ids4[i]);
    send_ref(32'h3D00_0000, 16'h0088, 16'd5);
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      tick();
      if (pair_valid) begin
        check("t4_nbr_id", pair_nbr_x, 32'h4300_0000 + 32'(ids4[got]));
        check("t4_ref_id", pair_ref_id, 16'h0088);
        check("t4_last", pair_last, (got == 4) ? 1'b1 : 1'b0);
      end
      pair_ready = (c % 3 == 0);
      if (pair_valid && pair_ready) got++;
    end
    check("t4_pair_count", 64'(got), 64'd5);
    tick();
    pair_ready = 1'b0;
    check("t4_after_last", pair_valid, 1'b0);
    tick();
    check("t4_done", ref_done, 1'b1);

    // Asynchronous reset while streaming with entries buffered
    for (int i = 0; i < 5; i++) push(32'h4400_0000 + i, 16'h00B0 + 16'(i));
    send_ref(32'h3B00_0000, 16'h0099, 16'd6);
    tick();
    check("t5_stalled_valid", pair_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_pair_valid", pair_valid, 1'b0);
    check("t5_rst_pair_nbr_x", pair_nbr_x, 32'h0);
    check("t5_rst_pair_ref_x", pair_ref_x, 32'h0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ref_ready", ref_ready, 1'b1);
    check("t5_rst_nbr_ready", nbr_ready, 1'b1);
    check("t5_rst_ref_done", ref_done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(32'h4500_0000, 16'h00C1);
    push(32'h4500_0010, 16'h00C2);
    pair_ready = 1'b1;
    send_ref(32'h3A00_0000, 16'h00AA, 16'd2);
    tick();
    check("t5_new_p0", pair_nbr_x, 32'h4500_0000);
    check("t5_new_p0_ref", pair_ref_x, 32'h3A00_0000);
    tick();
    check("t5_new_p1", pair_nbr_x, 32'h4500_0010);
    check("t5_new_p1_last", pair_last, 1'b1);
    tick();
    tick();
    check("t5_new_done", ref_done, 1'b1);

`ifdef PAIR_SKIP_SELF_EN
    // Self-pair skipping
    push(32'h4600_0000, 16'd3);
    push(32'h4600_0010, 16'd7);
    push(32'h4600_0020, 16'd9);
    send_ref(32'h3900_0000, 16'd7, 16'd3);
    check("t6_skip_clear", skip_count, 16'd0);
    tick();
    check("t6_p0", pair_nbr_x, 32'h4600_0000);
    tick();
    check("t6_skip_gap", pair_valid, 1'b0);
    check("t6_skip_count", skip_count, 16'd1);
    tick();
    check("t6_p1", pair_nbr_x, 32'h4600_0020);
    check("t6_p1_last", pair_last, 1'b1);
    tick();
    tick();
    check("t6_done", ref_done, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
